// File: rtl/sat_mult_pkg.sv
// Shared widths, saturation limits and the multiplier result type used by
// the round-robin saturating multiplier arbiter.
package sat_mult_pkg;

    localparam int unsigned OP_W  = 16;
    localparam int unsigned RES_W = 32;

    localparam logic [RES_W-1:0] POS_MAX = 32'h7FFF_FFFF;
    localparam logic [RES_W-1:0] NEG_MAX = 32'h8000_0000;

    typedef struct packed {
        logic             sat_flag;
        logic [RES_W-1:0] data;
    } res_t;

endpackage

// File: rtl/sat_mult_core.sv
// Combinational 16x16 signed multiply with saturation into the Q-shifted
// 32-bit result format (product shifted left by two).
module sat_mult_core
    import sat_mult_pkg::*;
(
    input  logic [OP_W-1:0] a_i,
    input  logic [OP_W-1:0] b_i,
    output res_t            res_o
);

    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] prod;

    assign a_ext = RES_W'($signed(a_i));
    assign b_ext = RES_W'($signed(b_i));
    assign prod  = a_ext * b_ext;

    always_comb begin
        res_o.sat_flag = 1'b0;
        res_o.data     = {prod[31], prod[28:0], 2'b00};
        // the two-bit left shift only fits when the top three bits agree
        if ((prod[31:29] != 3'b000) && (prod[31:29] != 3'b111)) begin
            res_o.sat_flag = 1'b1;
            res_o.data     = prod[31] ? NEG_MAX : POS_MAX;
        end
    end

endmodule

// File: rtl/sat_mult_arbiter.sv
// Round-robin arbiter sharing one two-stage saturating multiplier among
// NUM_REQ requesters. Define SAT_MULT_SAT_CNT_EN to add the o_sat_cnt port.
module sat_mult_arbiter
    import sat_mult_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [NUM_REQ*16-1:0]   i_req_a,
    input  logic [NUM_REQ*16-1:0]   i_req_b,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic [ID_W-1:0]         o_res_id,
    output logic [31:0]             o_res_data
`ifdef SAT_MULT_SAT_CNT_EN
    ,
    output logic [15:0]             o_sat_cnt
`endif
);

    logic [ID_W-1:0]    last_q;
    logic               s1_valid_q;
    logic [OP_W-1:0]    s1_a_q, s1_b_q;
    logic [ID_W-1:0]    s1_id_q;
    logic               res_valid_q;
    logic [ID_W-1:0]    res_id_q;
    logic [RES_W-1:0]   res_data_q;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_found;
    logic [ID_W-1:0]    idx;
    logic [OP_W-1:0]    sel_a, sel_b;
    logic               adv1, adv2, xfer;
    res_t               core_res;

    assign adv2        = !res_valid_q | i_res_ready;
    assign adv1        = !s1_valid_q | adv2;
    assign o_req_ready = adv1 ? gnt : '0;
    assign xfer        = |o_req_ready;

    // search starts one past the last granted index and wraps
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_found = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((32'(last_q) + k) % NUM_REQ);
            if (!gnt_found && i_req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
            end
        end
        if (gnt_found) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                sel_a = i_req_a[k*OP_W +: OP_W];
                sel_b = i_req_b[k*OP_W +: OP_W];
            end
        end
    end

    sat_mult_core u_core (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .res_o (core_res)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_q      <= ID_W'(NUM_REQ - 1);
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            if (xfer) begin
                last_q <= gnt_id;
            end
            if (adv1) begin
                s1_valid_q <= xfer;
                if (xfer) begin
                    s1_a_q  <= sel_a;
                    s1_b_q  <= sel_b;
                    s1_id_q <= gnt_id;
                end
            end
            if (adv2) begin
                res_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_id_q   <= s1_id_q;
                    res_data_q <= core_res.data;
                end
            end
        end
    end

    assign o_res_valid = res_valid_q;
    assign o_res_id    = res_id_q;
    assign o_res_data  = res_data_q;

`ifdef SAT_MULT_SAT_CNT_EN
    logic [15:0] sat_cnt_q;
    logic [15:0] sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (adv2 && s1_valid_q && core_res.sat_flag && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign o_sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_sat_mult_arbiter.sv
// Randomised bench for sat_mult_arbiter against a queue-based reference:
// a two-entry elastic pipe whose entries surface one edge after acceptance.
module tb_sat_mult_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid, req_ready;
    logic [N*16-1:0]     req_a, req_b;
    logic                res_valid, res_ready;
    logic [IDW-1:0]      res_id;
    logic [31:0]         res_data;
`ifdef SAT_MULT_SAT_CNT_EN
    logic [15:0]         sat_cnt;
`endif

    always #5 clk = ~clk;

    sat_mult_arbiter #(.NUM_REQ(N)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_id    (res_id),
        .o_res_data  (res_data)
`ifdef SAT_MULT_SAT_CNT_EN
        ,
        .o_sat_cnt   (sat_cnt)
`endif
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        bit          sat;
        int          t;
        bit          counted;
    } item_t;

    int          errors = 0;
    int          checks = 0;
    item_t       q[$];
    int          m_last = N - 1;
    int          m_sat  = 0;
    int          n_edge = 0;
    bit          pend[N];
    logic [15:0] opa[N], opb[N];
    bit          do_reset = 1'b0;
    bit          auto_req = 1'b0;
    int          p_req = 50;
    int          p_rdy = 100;
    int          glog[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n_edge);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            output bit sat);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        sat = 1'b1;
        if (p > 64'sd536870911)  return 32'h7FFF_FFFF;
        if (p < -64'sd536870912) return 32'h8000_0000;
        sat = 1'b0;
        return 32'(p * 4);
    endfunction

    function automatic logic [15:0] rand_op();
        case ($urandom_range(5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'($urandom_range(255));
            default: return 16'($urandom);
        endcase
    endfunction

    // accepted when the pipe holds fewer than two, or the output drains this edge
    function automatic int model_grant();
        if (!(q.size() < 2 || res_ready)) return -1;
        for (int k = 1; k <= N; k++) begin
            if (pend[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic present(input int i, input logic [15:0] a, input logic [15:0] b);
        pend[i] = 1'b1;
        opa[i]  = a;
        opb[i]  = b;
    endtask

    task automatic step();
        int          g;
        int          dg;
        bit          s;
        logic [31:0] d;
        bit          exp_valid;
        if (auto_req) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(99) < p_req) present(i, rand_op(), rand_op());
            end
        end
        res_ready = ($urandom_range(99) < p_rdy);
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*16 +: 16]  = opa[i];
            req_b[i*16 +: 16]  = opb[i];
        end
        rst = do_reset;
        #1;
        g = model_grant();
        check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
        dg = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) dg = i;
        if (dg >= 0) glog.push_back(dg);

        @(posedge clk);
        if (do_reset) begin
            q.delete();
            m_last = N - 1;
            m_sat  = 0;
            n_edge++;
        end else begin
            if (q.size() > 0 && n_edge >= q[0].t + 1 && res_ready) void'(q.pop_front());
            n_edge++;
            if (g >= 0) begin
                d = ref_mul(opa[g], opb[g], s);
                q.push_back('{g, d, s, n_edge, 1'b0});
                pend[g] = 1'b0;
                m_last  = g;
            end
            for (int i = 0; i < q.size(); i++) begin
                if (!q[i].counted && n_edge >= q[i].t + 1) begin
                    q[i].counted = 1'b1;
                    if (q[i].sat && m_sat < 65535) m_sat++;
                end
            end
        end
        #1;
        exp_valid = (q.size() > 0) && (n_edge >= q[0].t + 1);
        check("res_valid", 32'(res_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("res_id", 32'(res_id), 32'(q[0].id));
            check("res_data", res_data, q[0].data);
        end
        if (do_reset) begin
            check("reset_id", 32'(res_id), 32'd0);
            check("reset_data", res_data, 32'd0);
        end
`ifdef SAT_MULT_SAT_CNT_EN
        check("sat_cnt", 32'(sat_cnt), 32'(m_sat));
`endif
    endtask

    task automatic reset_cycle();
        do_reset = 1'b1;
        step();
        do_reset = 1'b0;
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            check(tag, (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            opa[i]  = '0;
            opb[i]  = '0;
        end

        reset_cycle();
        reset_cycle();

        present(0, 16'h0100, 16'h0200);
        repeat (4) step();

        present(0, 16'h7FFF, 16'h7FFF);
        present(1, 16'h8000, 16'h7FFF);
        present(2, 16'hFFFF, 16'h0004);
        repeat (6) step();

        reset_cycle();
        glog.delete();
        auto_req = 1'b1;
        p_req    = 100;
        repeat (8) step();
        check_order("rr_all_valid", '{0, 1, 2, 3, 0, 1});

        p_rdy = 0;
        repeat (3) step();
        p_rdy    = 100;
        auto_req = 1'b0;
        repeat (10) step();

        auto_req = 1'b1;
        repeat (3) step();
        reset_cycle();
        glog.delete();
        step();
        check_order("grant_after_reset", '{0});
        auto_req = 1'b0;
        repeat (8) step();

        reset_cycle();
        glog.delete();
        present(1, 16'h1234, 16'h0042);
        present(3, 16'hF00D, 16'h0101);
        step();
        present(2, 16'h4000, 16'h4000);
        repeat (3) step();
        check_order("late_joiner", '{1, 2, 3});

        auto_req = 1'b1;
        for (int r = 0; r < 6; r++) begin
            p_req = $urandom_range(90, 10);
            p_rdy = $urandom_range(100, 10);
            repeat (400) step();
        end
        auto_req = 1'b0;
        p_rdy    = 100;
        repeat (12) step();
        check("drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
